// File: rtl/nes_cpu_run_controller.sv
// Run controller for the 6502 core: gates the CPU clock enable for N-cycle steps,
// free run and run-to-breakpoint, and reports completion cause and cycle count.
module nes_cpu_run_controller #(
    parameter int NUM_BREAKPOINTS = 4,
    parameter int BP_INDEX_WIDTH  = 2,
    parameter int ADDR_WIDTH      = 16,
    parameter int COUNT_WIDTH     = 16
) (
    input  logic                      i_clk_5mhz,
    input  logic                      i_reset_n,
    input  logic                      i_cmd_valid,
    input  logic [1:0]                i_cmd,
    input  logic [COUNT_WIDTH-1:0]    i_cmd_count,
    output logic                      o_cmd_ready,
    input  logic                      i_bp_wr_en,
    input  logic [BP_INDEX_WIDTH-1:0] i_bp_wr_index,
    input  logic [ADDR_WIDTH-1:0]     i_bp_wr_address,
    input  logic                      i_bp_wr_enable,
    input  logic [ADDR_WIDTH-1:0]     i_cpu_address,
    input  logic                      i_cpu_sync,
    output logic                      o_cpu_clk_en,
    output logic                      o_busy,
    output logic                      o_done,
    output logic [1:0]                o_done_reason,
    output logic [BP_INDEX_WIDTH-1:0] o_bp_hit_index,
    output logic [COUNT_WIDTH-1:0]    o_cycles_executed,
    output logic [1:0]                o_dbg_state
);

    // Handshake: a command is taken on any cycle with i_cmd_valid & o_cmd_ready
    // (ready = IDLE). STOP is the one command honoured while busy.
    localparam logic [1:0] CMD_STOP      = 2'd0;
    localparam logic [1:0] CMD_STEP_N    = 2'd1;
    localparam logic [1:0] CMD_RUN       = 2'd2;
    localparam logic [1:0] CMD_RUN_TO_BP = 2'd3;

    localparam logic [1:0] REASON_COUNT = 2'd0;
    localparam logic [1:0] REASON_BP    = 2'd1;
    localparam logic [1:0] REASON_ABORT = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_STEPPING = 2'd1,
        ST_RUNNING  = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic                        enable_q, enable_d;
    logic                        bp_mode_q, bp_mode_d;
    logic                        first_q, first_d;
    logic [COUNT_WIDTH-1:0]      remaining_q, remaining_d;
    logic [COUNT_WIDTH-1:0]      cycles_q, cycles_d;
    logic                        done_q, done_d;
    logic [1:0]                  reason_q, reason_d;
    logic [BP_INDEX_WIDTH-1:0]   hit_q, hit_d;
    logic [ADDR_WIDTH-1:0]       bp_addr_q [NUM_BREAKPOINTS];
    logic [ADDR_WIDTH-1:0]       bp_addr_d [NUM_BREAKPOINTS];
    logic [NUM_BREAKPOINTS-1:0]  bp_en_q, bp_en_d;

    logic                        bp_match;
    logic [BP_INDEX_WIDTH-1:0]   bp_match_idx;
    logic                        w_bp_halt;
    logic                        cpu_clk_en;
    logic                        stop_req;

    // Scan high to low so the lowest matching entry wins.
    always_comb begin
        bp_match     = 1'b0;
        bp_match_idx = '0;
        for (int i = NUM_BREAKPOINTS - 1; i >= 0; i--) begin
            if (bp_en_q[i] && (bp_addr_q[i] == i_cpu_address)) begin
                bp_match     = 1'b1;
                bp_match_idx = i[BP_INDEX_WIDTH-1:0];
            end
        end
    end

    assign w_bp_halt  = bp_mode_q & enable_q & ~first_q & i_cpu_sync & bp_match;
    assign cpu_clk_en = enable_q & ~w_bp_halt;
    assign stop_req   = i_cmd_valid & (i_cmd == CMD_STOP);

    always_comb begin
        bp_en_d = bp_en_q;
        for (int i = 0; i < NUM_BREAKPOINTS; i++) begin
            bp_addr_d[i] = bp_addr_q[i];
        end
        if (i_bp_wr_en) begin
            bp_addr_d[i_bp_wr_index] = i_bp_wr_address;
            bp_en_d[i_bp_wr_index]   = i_bp_wr_enable;
        end
    end

    always_comb begin
        state_d     = state_q;
        enable_d    = enable_q;
        bp_mode_d   = bp_mode_q;
        first_d     = 1'b0;
        remaining_d = remaining_q;
        cycles_d    = cycles_q;
        done_d      = 1'b0;
        reason_d    = reason_q;
        hit_d       = hit_q;

        if (cpu_clk_en && (cycles_q != '1)) begin
            cycles_d = cycles_q + 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (i_cmd_valid && (i_cmd != CMD_STOP)) begin
                    cycles_d  = '0;
                    reason_d  = REASON_COUNT;
                    hit_d     = '0;
                    first_d   = 1'b1;
                    bp_mode_d = (i_cmd == CMD_RUN_TO_BP);
                    if (i_cmd == CMD_STEP_N) begin
                        if (i_cmd_count == '0) begin
                            done_d    = 1'b1;
                            bp_mode_d = 1'b0;
                        end else begin
                            state_d     = ST_STEPPING;
                            enable_d    = 1'b1;
                            remaining_d = i_cmd_count;
                        end
                    end else begin
                        state_d  = ST_RUNNING;
                        enable_d = 1'b1;
                    end
                end
            end
            ST_STEPPING: begin
                remaining_d = remaining_q - 1'b1;
                // Count completion outranks a coincident STOP.
                if (remaining_q == {{(COUNT_WIDTH-1){1'b0}}, 1'b1}) begin
                    state_d  = ST_IDLE;
                    enable_d = 1'b0;
                    done_d   = 1'b1;
                    reason_d = REASON_COUNT;
                end else if (stop_req) begin
                    state_d  = ST_IDLE;
                    enable_d = 1'b0;
                    done_d   = 1'b1;
                    reason_d = REASON_ABORT;
                end
            end
            ST_RUNNING: begin
                if (w_bp_halt) begin
                    state_d   = ST_IDLE;
                    enable_d  = 1'b0;
                    bp_mode_d = 1'b0;
                    done_d    = 1'b1;
                    reason_d  = REASON_BP;
                    hit_d     = bp_match_idx;
                end else if (stop_req) begin
                    state_d   = ST_IDLE;
                    enable_d  = 1'b0;
                    bp_mode_d = 1'b0;
                    done_d    = 1'b1;
                    reason_d  = REASON_ABORT;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                enable_d  = 1'b0;
                bp_mode_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk_5mhz or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= ST_IDLE;
            enable_q    <= 1'b0;
            bp_mode_q   <= 1'b0;
            first_q     <= 1'b0;
            remaining_q <= '0;
            cycles_q    <= '0;
            done_q      <= 1'b0;
            reason_q    <= REASON_COUNT;
            hit_q       <= '0;
            bp_en_q     <= '0;
            for (int i = 0; i < NUM_BREAKPOINTS; i++) begin
                bp_addr_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            enable_q    <= enable_d;
            bp_mode_q   <= bp_mode_d;
            first_q     <= first_d;
            remaining_q <= remaining_d;
            cycles_q    <= cycles_d;
            done_q      <= done_d;
            reason_q    <= reason_d;
            hit_q       <= hit_d;
            bp_en_q     <= bp_en_d;
            for (int i = 0; i < NUM_BREAKPOINTS; i++) begin
                bp_addr_q[i] <= bp_addr_d[i];
            end
        end
    end

    assign o_cmd_ready       = (state_q == ST_IDLE);
    assign o_busy            = (state_q != ST_IDLE);
    assign o_cpu_clk_en      = cpu_clk_en;
    assign o_done            = done_q;
    assign o_done_reason     = reason_q;
    assign o_bp_hit_index    = hit_q;
    assign o_cycles_executed = cycles_q;
    assign o_dbg_state       = state_q;

endmodule

// File: tb/tb_nes_cpu_run_controller.sv
// Directed bench for nes_cpu_run_controller: expected completions go into a queue,
// a monitor pops one per o_done pulse and compares reason/index/cycle count.
module tb_nes_cpu_run_controller;

    localparam int W = 20;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic [1:0]  cmd;
    logic [15:0] cmd_count;
    logic        cmd_ready;
    logic        bp_wr_en;
    logic [1:0]  bp_wr_index;
    logic [15:0] bp_wr_address;
    logic        bp_wr_enable;
    logic [15:0] cpu_address;
    logic        cpu_sync;
    logic        cpu_clk_en;
    logic        busy;
    logic        done;
    logic [1:0]  done_reason;
    logic [1:0]  bp_hit_index;
    logic [15:0] cycles_executed;
    logic [1:0]  dbg_state;

    logic [W-1:0] exp_q[$];
    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    int en_cnt   = 0;
    int en_start;

    nes_cpu_run_controller dut (
        .i_clk_5mhz       (clk),
        .i_reset_n        (rst_n),
        .i_cmd_valid      (cmd_valid),
        .i_cmd            (cmd),
        .i_cmd_count      (cmd_count),
        .o_cmd_ready      (cmd_ready),
        .i_bp_wr_en       (bp_wr_en),
        .i_bp_wr_index    (bp_wr_index),
        .i_bp_wr_address  (bp_wr_address),
        .i_bp_wr_enable   (bp_wr_enable),
        .i_cpu_address    (cpu_address),
        .i_cpu_sync       (cpu_sync),
        .o_cpu_clk_en     (cpu_clk_en),
        .o_busy           (busy),
        .o_done           (done),
        .o_done_reason    (done_reason),
        .o_bp_hit_index   (bp_hit_index),
        .o_cycles_executed(cycles_executed),
        .o_dbg_state      (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #100 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor / scoreboard
    initial begin
        logic [W-1:0] exp_v;
        logic [W-1:0] act_v;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (cpu_clk_en) en_cnt++;
                if (done) begin
                    done_cnt++;
                    act_v = {done_reason, bp_hit_index, cycles_executed};
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_done: got 0x%0h expected no completion", act_v);
                    end else begin
                        exp_v = exp_q.pop_front();
                        check("done_result", 32'(act_v), 32'(exp_v));
                    end
                end
            end
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] c, input logic [15:0] n);
        cmd_valid = 1'b1;
        cmd       = c;
        cmd_count = n;
        tick();
        cmd_valid = 1'b0;
        cmd_count = '0;
    endtask

    task automatic bp_write(input logic [1:0] idx, input logic [15:0] addr, input logic en);
        bp_wr_en      = 1'b1;
        bp_wr_index   = idx;
        bp_wr_address = addr;
        bp_wr_enable  = en;
        tick();
        bp_wr_en = 1'b0;
    endtask

    task automatic expect_done(input logic [1:0] reason, input logic [1:0] idx, input logic [15:0] cyc);
        exp_q.push_back({reason, idx, cyc});
    endtask

    task automatic wait_done(input string name, input int budget);
        int start;
        int n;
        start = done_cnt;
        n = 0;
        while (done_cnt == start && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (done_cnt == start) begin
            failures++;
            $display("FAIL %s_timeout: got no done after %0d cycles expected done", name, budget);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd = 2'd0; cmd_count = '0;
        bp_wr_en = 1'b0; bp_wr_index = '0; bp_wr_address = '0; bp_wr_enable = 1'b0;
        cpu_address = '0; cpu_sync = 1'b0;
        tick(); tick();
        check("reset_ready", 32'(cmd_ready), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_clk_en", 32'(cpu_clk_en), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_cycles", 32'(cycles_executed), 32'd0);
        rst_n = 1'b1;
        tick();

        // STEP_N 3
        en_start = en_cnt;
        expect_done(2'd0, 2'd0, 16'd3);
        issue(2'd1, 16'd3);
        wait_done("step3", 10);
        check("step3_enables", 32'(en_cnt - en_start), 32'd3);
        check("step3_ready", 32'(cmd_ready), 32'd1);
        check("step3_busy", 32'(busy), 32'd0);

        // STEP_N 0
        en_start = en_cnt;
        expect_done(2'd0, 2'd0, 16'd0);
        issue(2'd1, 16'd0);
        check("step0_not_busy", 32'(busy), 32'd0);
        wait_done("step0", 5);
        check("step0_enables", 32'(en_cnt - en_start), 32'd0);

        // STOP in IDLE is ignored
        issue(2'd0, 16'd0);
        tick();
        check("stop_idle_busy", 32'(busy), 32'd0);

        // Breakpoint on active cycle 5
        bp_write(2'd2, 16'h8004, 1'b1);
        expect_done(2'd1, 2'd2, 16'd4);
        issue(2'd3, 16'd0);
        repeat (4) tick();
        cpu_sync = 1'b1; cpu_address = 16'h8004;
        #50;
        check("bp_halt_clk_en", 32'(cpu_clk_en), 32'd0);
        wait_done("bp_hit", 5);
        cpu_sync = 1'b0; cpu_address = '0;

        // Resume onto the same breakpoint: first cycle not trapped
        cpu_sync = 1'b1; cpu_address = 16'h8004;
        expect_done(2'd1, 2'd2, 16'd1);
        issue(2'd3, 16'd0);
        #50;
        check("resume_first_clk_en", 32'(cpu_clk_en), 32'd1);
        wait_done("resume", 5);
        cpu_sync = 1'b0; cpu_address = '0;

        // RUN, ignored STEP_N, STOP after 10 enables
        en_start = en_cnt;
        expect_done(2'd2, 2'd0, 16'd11);
        issue(2'd2, 16'd0);
        tick();
        issue(2'd1, 16'd2);
        repeat (8) tick();
        issue(2'd0, 16'd0);
        wait_done("run_stop", 5);
        check("run_stop_enables", 32'(en_cnt - en_start), 32'd11);

        // Last STEP_N enable coincident with STOP -> COUNT
        expect_done(2'd0, 2'd0, 16'd2);
        issue(2'd1, 16'd2);
        tick();
        issue(2'd0, 16'd0);
        wait_done("step_stop_tie", 5);

        // Two entries match: lowest index wins
        bp_write(2'd0, 16'h1234, 1'b1);
        bp_write(2'd1, 16'h1234, 1'b1);
        expect_done(2'd1, 2'd0, 16'd1);
        issue(2'd3, 16'd0);
        tick();
        cpu_sync = 1'b1; cpu_address = 16'h1234;
        wait_done("multi_match", 5);
        cpu_sync = 1'b0; cpu_address = '0;

        // Async reset mid-RUN
        issue(2'd2, 16'd0);
        repeat (3) tick();
        rst_n = 1'b0;
        #10;
        check("rst_mid_clk_en", 32'(cpu_clk_en), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_ready", 32'(cmd_ready), 32'd1);
        check("rst_mid_cycles", 32'(cycles_executed), 32'd0);
        tick();
        rst_n = 1'b1;
        tick(); tick();

        // Breakpoints cleared by reset: match pattern must not halt
        cpu_sync = 1'b1; cpu_address = 16'h1234;
        expect_done(2'd2, 2'd0, 16'd4);
        issue(2'd3, 16'd0);
        repeat (3) tick();
        check("bp_cleared_busy", 32'(busy), 32'd1);
        issue(2'd0, 16'd0);
        wait_done("bp_cleared", 5);
        cpu_sync = 1'b0; cpu_address = '0;

        repeat (3) tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
